// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit with architectural HI/LO registers
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, neg_lo, neg_hi, dz;
    logic [WIDTH-1:0]   m, p_hi, p_lo, a_raw;
    logic               sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    assign sgn      = ~op[0];
    assign abs_a    = (sgn && A[WIDTH-1]) ? -A : A;
    assign abs_b    = (sgn && B[WIDTH-1]) ? -B : B;
    assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
    assign div_sh   = {p_hi, p_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, m};
    assign prod     = {p_hi, p_lo};
    assign prod_fix = neg_lo ? -prod : prod;
    // Control FSM, shift-add / restoring-divide datapath and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz          <= 1'b0;
            m           <= '0;
            p_hi        <= '0;
            p_lo        <= '0;
            a_raw       <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) HI <= wdata;
                    if (lo_we) LO <= wdata;
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_lo <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_hi <= sgn & A[WIDTH-1];
                        dz     <= op[1] && (B == '0);
                        a_raw  <= A;
                        m      <= op[1] ? abs_b : abs_a;
                        p_lo   <= op[1] ? abs_a : abs_b;
                        p_hi   <= '0;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        p_hi <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        p_hi <= mul_sum[WIDTH:1];
                        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end else if (dz) begin
                        HI <= a_raw;
                        LO <= '1;
                    end else begin
                        HI <= neg_hi ? -p_hi : p_hi;
                        LO <= neg_lo ? -p_lo : p_lo;
                    end
                    div_by_zero <= is_div & dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    cnt         <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized self-checking bench for mul_div_unit against an arithmetic model
module tb_mul_div_unit;
    localparam int W = 32;
    logic clk = 0, rst_n = 0, start = 0, hi_we = 0, lo_we = 0;
    logic [1:0] op = 0;
    logic [W-1:0] a = 0, b = 0, wdata = 0;
    logic busy, done, div_by_zero;
    logic [W-1:0] hi, lo;
    logic [W-1:0] m_hi = 0, m_lo = 0;
    int checks = 0, errors = 0;

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint sx = longint'($signed(x)), sy = longint'($signed(y));
        longint ux = longint'({32'b0, x}), uy = longint'({32'b0, y});
        longint q, r;
        logic [63:0] p;
        z = 0;
        if (o == 2'd0) begin
            p = sx * sy;
            h = p[63:32]; l = p[31:0];
        end else if (o == 2'd1) begin
            p = {32'b0, x} * {32'b0, y};
            h = p[63:32]; l = p[31:0];
        end else if (y == 0) begin
            h = x; l = 32'hffffffff; z = 1;
        end else begin
            q = (o == 2'd2) ? sx / sy : ux / uy;
            r = (o == 2'd2) ? sx % sy : ux % uy;
            h = r[31:0]; l = q[31:0];
        end
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
        logic [31:0] eh, el;
        logic ez;
        int n;
        model(o, x, y, eh, el, ez);
        op = o; a = x; b = y; start = 1;
        @(posedge clk); #1;
        start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
        check("busy_after_start", busy, 1);
        check("done_low_after_start", done, 0);
        n = 1;
        while (!done && n < 40) begin
            if (n == poke) begin start = 1; hi_we = 1; lo_we = 1; wdata = $urandom; end
            @(posedge clk); #1;
            if (n == poke) begin
                start = 0; hi_we = 0; lo_we = 0;
                check("hi_hold_busy", hi, m_hi);
                check("lo_hold_busy", lo, m_lo);
            end
            n++;
        end
        check("latency", n, 34);
        check("busy_at_done", busy, 0);
        check("hi_result", hi, eh);
        check("lo_result", lo, el);
        check("div_by_zero", div_by_zero, ez);
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        int seen;
        logic [1:0] o;
        logic [31:0] x, y;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        rst_n = 1;
        @(posedge clk); #1;
        hi_we = 1; wdata = 32'h1234;
        @(posedge clk); #1;
        hi_we = 0;
        check("mthi", hi, 32'h1234);
        check("mthi_lo_untouched", lo, 0);
        m_hi = 32'h1234;
        op = 2'd1; a = 5; b = 7; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        m_hi = 0; m_lo = 0;
        @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst_no_done", seen, 0);
        run_op(2'd1, 32'hffffffff, 32'hffffffff, 0);
        check("multu_max_hi", hi, 32'hfffffffe);
        check("multu_max_lo", lo, 32'h00000001);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        run_op(2'd0, -32'sd3, 32'd7, 0);
        check("mult_neg_lo", lo, 32'hffffffeb);
        run_op(2'd2, -32'sd7, 32'd2, 0);
        check("div_neg_lo", lo, 32'hfffffffd);
        check("div_neg_hi", hi, 32'hffffffff);
        run_op(2'd3, 32'd100, 32'd0, 0);
        check("divu_zero_hi", hi, 32'd100);
        run_op(2'd2, 32'h80000000, 32'hffffffff, 0);
        check("div_ovf_lo", lo, 32'h80000000);
        run_op(2'd2, 32'hfffffff9, 32'd0, 0);
        run_op(2'd0, 32'd1234567, -32'sd89, 5);
        run_op(2'd3, 32'd1000, 32'd7, 0);
        op = 2'd1; a = 3; b = 4; start = 1; hi_we = 1; wdata = 32'habcd;
        @(posedge clk); #1;
        start = 0; hi_we = 0;
        check("mthi_with_start", hi, 32'habcd);
        seen = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            seen++;
        end
        check("start_mthi_latency", seen, 33);
        check("start_mthi_hi", hi, 0);
        check("start_mthi_lo", lo, 12);
        m_hi = 0; m_lo = 12;
        repeat (40) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            run_op(o, x, y, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
- Sits beside the combinational ALU and takes the same forwarded 32-bit operand pair.
- Executes MULT, MULTU, DIV and DIVU in a fixed multi-cycle sequence and holds results in architectural HI/LO registers, read by MFHI/MFLO.
- Hazard unit stalls the pipeline on busy.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO update
- div_by_zero  output  1  pulse with done when a divide had B==0
- HI  output  WIDTH  high product / remainder
- LO  output  WIDTH  low product / quotient

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; HI=LO=0; busy=done=div_by_zero=0; counter=0.
  - Reset mid-operation aborts the operation with no HI/LO update.
- States:
  - IDLE: on start=1, latch op, |A|, |B| and the result signs → CALC, counter=0, busy=1 from the next cycle.
  - CALC: one iteration per cycle for exactly WIDTH cycles (counter 0..WIDTH-1). At counter==WIDTH-1 → FIX.
  - FIX: apply sign correction, write HI/LO, done=1 for the following cycle, busy=0 → IDLE.
- Latency:
  - Start sampled at edge k → busy high for cycles after edges k..k+WIDTH.
  - HI/LO valid and done=1 after edge k+WIDTH+1 (33 cycles for WIDTH=32).
  - A new start may be accepted in the same cycle done is high.
- Multiply:
  - Shift-add on magnitudes, 2·WIDTH product; HI=upper, LO=lower.
  - Signed: negate the full product if sign(A)≠sign(B). Unsigned: no correction.
- Divide:
  - Restoring division on magnitudes.
  - Signed: quotient truncates toward zero (negated if signs differ); remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV) → LO=0x80000000, HI=0; no flag.
- Divide by zero (B==0, DIV or DIVU):
  - Same latency.
  - LO=0xFFFFFFFF, HI=A (original, unsigned view).
  - div_by_zero=1 together with done.
- Start while busy: ignored (hazard unit must not issue; no queueing).
- hi_we/lo_we:
  - Honoured only in IDLE; ignored when busy.
  - Same cycle as an accepted start: the write occurs, and the computation later overwrites HI/LO.
  - hi_we and lo_we together: both written with wdata.
- A, B, op may change after the start cycle without effect.
- HI/LO hold between operations.

Test Plan:
- Reset mid-CALC: start MULTU 5×7, drop rst_n at cycle 10 → HI=LO=0, busy=0 immediately, no done pulse.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done one-cycle pulse.
- MULT −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=100, div_by_zero=1 with done. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Back-to-back: second start asserted while busy (ignored, HI/LO reflect the first op only); start in the done cycle accepted, second result after 33 more cycles.
- MTHI 0x1234 in IDLE → HI=0x1234 next cycle. MTLO while busy → LO unchanged until done writes the result.
